glitch_monitor: RTL and testbench

- Observing end of the glitch-pulse interface.
- Samples the `trigger` and `glitch` lines and measures two intervals: trigger rise to glitch rise (delay), and glitch rise to glitch fall (width).
- Reports each measurement once, with pass/fail against expected values and error flags.
- Sits on the FPGA beside the glitch generator, or on a second board, for closed-loop calibration and self-test.

---
 rtl/glitch_mon_pkg.sv | 24 ++
 rtl/glitch_mon_edge.sv | 51 +++++
 rtl/glitch_monitor.sv | 177 +++++++++++++++++
 tb/tb_glitch_monitor.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/glitch_mon_pkg.sv
// Shared types and helpers for the glitch monitor: FSM state encoding,
// default counter width and a saturating increment.
package glitch_mon_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DELAY    = 3'd1,
    WIDTH    = 3'd2,
    REPORT   = 3'd3,
    WAIT_REL = 3'd4
  } state_t;

  localparam int CNT_WIDTH_DEFAULT = 32;
  localparam int SAT_MAX_WIDTH     = 64;

  // Increments value but sticks at the all-ones pattern of the given width.
  function automatic logic [SAT_MAX_WIDTH-1:0] sat_inc(input logic [SAT_MAX_WIDTH-1:0] value,
                                                      input int width);
    logic [SAT_MAX_WIDTH-1:0] all_ones;
    all_ones = (width >= SAT_MAX_WIDTH) ? '1 : ((64'd1 << width) - 64'd1);
    return (value >= all_ones) ? all_ones : value + 64'd1;
  endfunction

endpackage

// File: rtl/glitch_mon_edge.sv
// Input capture and rise/fall detection for one observed line.
// Define GLITCH_MON_SYNC_EN to insert a 2-flop synchroniser ahead of the capture flop.
module glitch_mon_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic pre;

`ifdef GLITCH_MON_SYNC_EN
  localparam int STAGES = 3;
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], din};
  end

  assign pre = sync_q[1];
`else
  localparam int STAGES = 1;
  assign pre = din;
`endif

  logic            x;
  logic            x_q;
  logic [STAGES:0] arm;

  // Edges stay masked until the pipeline has refilled after reset, so a line
  // already high at reset release never looks like a fresh edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      x   <= 1'b0;
      x_q <= 1'b0;
      arm <= '0;
    end else begin
      x   <= pre;
      x_q <= x;
      arm <= {arm[STAGES-1:0], 1'b1};
    end
  end

  assign level = x;
  assign rise  = arm[STAGES] &  x & ~x_q;
  assign fall  = arm[STAGES] & ~x &  x_q;

endmodule

// File: rtl/glitch_monitor.sv
// Measures trigger-rise to glitch-rise delay and glitch width, reporting each
// result once with pass/fail. Optional input synchronisers: GLITCH_MON_SYNC_EN.
module glitch_monitor
  import glitch_mon_pkg::*;
#(
  parameter int          CNT_WIDTH     = CNT_WIDTH_DEFAULT,
  parameter logic [31:0] EXP_DELAY     = 32'd200_000_000,
  parameter logic [31:0] EXP_WIDTH     = 32'd200,
  parameter logic [31:0] TOLERANCE     = 32'd2,
  parameter logic [31:0] TIMEOUT_COUNT = 32'd400_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trigger,
  input  logic                 glitch,
  output logic                 busy,
  output logic                 result_valid,
  output logic [CNT_WIDTH-1:0] delay_count,
  output logic [CNT_WIDTH-1:0] width_count,
  output logic                 pass,
  output logic                 timeout,
  output logic                 aborted,
  output logic                 spurious
);

  localparam logic [CNT_WIDTH-1:0] EXP_D     = CNT_WIDTH'(EXP_DELAY);
  localparam logic [CNT_WIDTH-1:0] EXP_W     = CNT_WIDTH'(EXP_WIDTH);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT_COUNT);
  localparam logic [CNT_WIDTH:0]   TOL       = (CNT_WIDTH+1)'(TOLERANCE);
  localparam logic [CNT_WIDTH-1:0] ONE       = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [CNT_WIDTH:0] abs_diff(input logic [CNT_WIDTH-1:0] a,
                                                  input logic [CNT_WIDTH-1:0] b);
    logic [CNT_WIDTH:0] ea;
    logic [CNT_WIDTH:0] eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    return (ea >= eb) ? (ea - eb) : (eb - ea);
  endfunction

  logic trig_level, trig_rise, trig_fall;
  logic glit_level, glit_rise, glit_fall;

  glitch_mon_edge u_trig_edge (
    .clk   (clk),
    .rst   (rst),
    .din   (trigger),
    .level (trig_level),
    .rise  (trig_rise),
    .fall  (trig_fall)
  );

  glitch_mon_edge u_glit_edge (
    .clk   (clk),
    .rst   (rst),
    .din   (glitch),
    .level (glit_level),
    .rise  (glit_rise),
    .fall  (glit_fall)
  );

  state_t               state;
  logic [CNT_WIDTH-1:0] counter;
  logic [CNT_WIDTH-1:0] counter_inc;
  logic [CNT_WIDTH-1:0] delay_meas;
  logic [CNT_WIDTH-1:0] width_meas;
  logic [CNT_WIDTH:0]   delay_diff;
  logic [CNT_WIDTH:0]   width_diff;
  logic                 err_timeout;
  logic                 err_abort;

  assign counter_inc = CNT_WIDTH'(sat_inc(SAT_MAX_WIDTH'(counter), CNT_WIDTH));

  // Measurements accumulate in internal registers and are copied to the
  // outputs only in REPORT, so the result fields stay stable between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      counter      <= '0;
      delay_meas   <= '0;
      width_meas   <= '0;
      delay_diff   <= '0;
      width_diff   <= '0;
      err_timeout  <= 1'b0;
      err_abort    <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      delay_count  <= '0;
      width_count  <= '0;
      pass         <= 1'b0;
      timeout      <= 1'b0;
      aborted      <= 1'b0;
      spurious     <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      spurious     <= 1'b0;
      case (state)
        IDLE: begin
          counter     <= '0;
          delay_meas  <= '0;
          width_meas  <= '0;
          err_timeout <= 1'b0;
          err_abort   <= 1'b0;
          if (trig_rise && glit_rise) begin
            delay_diff <= abs_diff('0, EXP_D);
            counter    <= ONE;
            state      <= WIDTH;
            busy       <= 1'b1;
          end else if (trig_rise) begin
            counter <= ONE;
            state   <= DELAY;
            busy    <= 1'b1;
          end else if (glit_rise) begin
            spurious <= 1'b1;
          end
        end

        // Glitch rise takes priority over the trigger dropping in the same cycle.
        DELAY: begin
          counter <= counter_inc;
          if (glit_rise) begin
            delay_meas <= counter;
            delay_diff <= abs_diff(counter, EXP_D);
            counter    <= ONE;
            state      <= WIDTH;
          end else if (trig_fall) begin
            err_abort <= 1'b1;
            state     <= REPORT;
          end else if (counter == TIMEOUT_C) begin
            err_timeout <= 1'b1;
            delay_meas  <= counter;
            state       <= REPORT;
          end
        end

        WIDTH: begin
          counter <= counter_inc;
          if (glit_fall) begin
            width_meas <= counter;
            width_diff <= abs_diff(counter, EXP_W);
            state      <= REPORT;
          end else if (counter == TIMEOUT_C) begin
            err_timeout <= 1'b1;
            width_meas  <= counter;
            state       <= REPORT;
          end
        end

        REPORT: begin
          result_valid <= 1'b1;
          delay_count  <= delay_meas;
          width_count  <= width_meas;
          timeout      <= err_timeout;
          aborted      <= err_abort;
          pass         <= !err_timeout && !err_abort &&
                          (delay_diff <= TOL) && (width_diff <= TOL);
          spurious     <= glit_rise;
          state        <= WAIT_REL;
        end

        WAIT_REL: begin
          spurious <= glit_rise;
          if (!trig_level && !glit_level) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_glitch_monitor.sv
// Scoreboard bench for glitch_monitor: directed trigger/glitch waveforms push
// expected results; negedge monitors pop and compare whenever result_valid fires.
module tb_glitch_monitor;

  typedef struct {
    int unsigned delay;
    int unsigned width;
    logic        pass;
    logic        tmo;
    logic        abrt;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic trigger, glitch;
  logic to_trigger, to_glitch;

  logic        m_busy, m_valid, m_pass, m_tmo, m_abrt, m_spur;
  logic [31:0] m_delay, m_width;
  logic        t_busy, t_valid, t_pass, t_tmo, t_abrt, t_spur;
  logic [31:0] t_delay, t_width;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int spur_main = 0;
  exp_t q_main[$];
  exp_t q_to[$];

  always @(posedge clk) cyc <= cyc + 1;

  glitch_monitor #(
    .CNT_WIDTH(32), .EXP_DELAY(32'd200), .EXP_WIDTH(32'd200),
    .TOLERANCE(32'd2), .TIMEOUT_COUNT(32'd1000)
  ) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .glitch(glitch),
    .busy(m_busy), .result_valid(m_valid), .delay_count(m_delay),
    .width_count(m_width), .pass(m_pass), .timeout(m_tmo),
    .aborted(m_abrt), .spurious(m_spur)
  );

  glitch_monitor #(
    .CNT_WIDTH(32), .EXP_DELAY(32'd200), .EXP_WIDTH(32'd200),
    .TOLERANCE(32'd2), .TIMEOUT_COUNT(32'd50)
  ) dut_to (
    .clk(clk), .rst(rst), .trigger(to_trigger), .glitch(to_glitch),
    .busy(t_busy), .result_valid(t_valid), .delay_count(t_delay),
    .width_count(t_width), .pass(t_pass), .timeout(t_tmo),
    .aborted(t_abrt), .spurious(t_spur)
  );

  function automatic exp_t mk(int unsigned d, int unsigned w, logic p, logic t,
                              logic a, int v);
    exp_t e;
    e.delay = d; e.width = w; e.pass = p; e.tmo = t; e.abrt = a; e.cyc = v;
    return e;
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkOutput(input int which, input logic [31:0] d, input logic [31:0] w,
                             input logic p, input logic t, input logic a, input logic b);
    exp_t e;
    if ((which == 0 && q_main.size() == 0) || (which == 1 && q_to.size() == 0)) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_result dut%0d: result_valid at cycle %0d, expected none",
               which, cyc);
      return;
    end
    if (which == 0) e = q_main.pop_front();
    else            e = q_to.pop_front();
    check_eq("result_cycle", cyc, e.cyc);
    check_eq("delay_count", d, e.delay);
    check_eq("width_count", w, e.width);
    check_eq("pass", {31'd0, p}, {31'd0, e.pass});
    check_eq("timeout", {31'd0, t}, {31'd0, e.tmo});
    check_eq("aborted", {31'd0, a}, {31'd0, e.abrt});
    check_eq("busy_at_result", {31'd0, b}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (m_valid) checkOutput(0, m_delay, m_width, m_pass, m_tmo, m_abrt, m_busy);
    if (t_valid) checkOutput(1, t_delay, t_width, t_pass, t_tmo, t_abrt, t_busy);
    if (m_spur) spur_main++;
  end

  // Sample c of the waveform is taken at the c-th posedge after the call;
  // e.cyc on entry is the sample index at which result_valid is expected.
  task automatic applyStimulus(input bit on_to, input int len, input int tl, input int th,
                               input int gl, input int gh, input int rst_at,
                               input bit expect_res, input exp_t e, output bit busy_seen);
    busy_seen = 1'b0;
    e.cyc = cyc + 1 + e.cyc;
    if (expect_res) begin
      if (on_to) q_to.push_back(e);
      else       q_main.push_back(e);
    end
    for (int c = 0; c < len; c++) begin
      if (on_to) begin
        to_trigger = (c >= tl && c < th);
        to_glitch  = (c >= gl && c < gh);
      end else begin
        trigger = (c >= tl && c < th);
        glitch  = (c >= gl && c < gh);
      end
      rst = (c == rst_at);
      @(posedge clk);
      #1;
      busy_seen = busy_seen | (on_to ? t_busy : m_busy);
    end
    trigger = 1'b0; glitch = 1'b0; to_trigger = 1'b0; to_glitch = 1'b0; rst = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_delay"}, m_delay, 32'd0);
    check_eq({tag, "_width"}, m_width, 32'd0);
    check_eq({tag, "_flags"}, {26'd0, m_busy, m_valid, m_pass, m_tmo, m_abrt, m_spur}, 32'd0);
  endtask

  initial begin
    bit bs;
    int spur_before;
    exp_t none;
    none = mk(0, 0, 0, 0, 0, 0);
    rst = 1'b1; trigger = 1'b0; glitch = 1'b0; to_trigger = 1'b0; to_glitch = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");

    applyStimulus(0, 430, 10, 420, 210, 410, -1, 1, mk(200, 200, 1, 0, 0, 412), bs);
    applyStimulus(0, 435, 10, 425, 213, 413, -1, 1, mk(203, 200, 0, 0, 0, 415), bs);
    applyStimulus(0, 430, 10, 420, 212, 412, -1, 1, mk(202, 200, 1, 0, 0, 414), bs);
    applyStimulus(0, 430, 10, 420, 210, 408, -1, 1, mk(200, 198, 1, 0, 0, 410), bs);
    applyStimulus(0, 430, 10, 420, 210, 407, -1, 1, mk(200, 197, 0, 0, 0, 409), bs);
    applyStimulus(0, 60,  10, 50,  -1,  -1,  -1, 1, mk(0, 0, 0, 0, 1, 52), bs);
    applyStimulus(0, 420, 10, 210, 210, 410, -1, 1, mk(200, 200, 1, 0, 0, 412), bs);
    applyStimulus(0, 230, 10, 220, 10,  210, -1, 1, mk(0, 200, 0, 0, 0, 212), bs);

    spur_before = spur_main;
    applyStimulus(0, 20, -1, -1, 5, 10, -1, 0, none, bs);
    check_eq("spurious_pulses", spur_main - spur_before, 32'd1);
    check_eq("busy_during_spurious", {31'd0, bs}, 32'd0);
    applyStimulus(0, 430, 10, 420, 210, 410, -1, 1, mk(200, 200, 1, 0, 0, 412), bs);

    applyStimulus(1, 90,  10, 80, -1, -1, -1, 1, mk(50, 0, 0, 1, 0, 62), bs);
    applyStimulus(1, 100, 10, 90, 20, 90, -1, 1, mk(10, 50, 0, 1, 0, 72), bs);

    applyStimulus(0, 320, 10, 400, 210, 400, 300, 0, none, bs);
    check_idle_outputs("midreset");
    applyStimulus(0, 430, 10, 420, 210, 410, -1, 1, mk(200, 200, 1, 0, 0, 412), bs);

    repeat (20) @(posedge clk);
    #1;
    check_eq("pending_main", q_main.size(), 32'd0);
    check_eq("pending_to", q_to.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
